mux_nto1_tdm: RTL and testbench

//  Parametrised N-to-1 data/valid multiplexer; successor to the fixed 2-to-1 lane mux.

---
 rtl/mux_nto1_tdm_if.sv | 43 ++++
 rtl/mux_nto1_tdm.sv | 111 +++++++++++
 tb/tb_mux_nto1_tdm.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mux_nto1_tdm_if.sv
// ---------------------------------------------------------------------------
// mux_nto1_tdm_if
//   Bundles the lane-side inputs and the serial-side outputs of the N-to-1
//   TDM multiplexer. The clock and reset are not part of this bundle.
//
//   Parameters: NUM_CH (lanes), WIDTH (bits per lane), SELW (= $clog2(NUM_CH))
//
//   Signals:
//     mode      0 = external select, 1 = internal round-robin
//     sel       lane select, only used when mode=0
//     in_data   flat lane bus, lane k at [k*WIDTH +: WIDTH]
//     in_valid  valid bit per lane
//     data_out  registered selected data
//     valid_out registered selected valid
//     lane_out  lane index behind the current data_out
//     frame_sof current output is lane 0 of a round-robin frame
//
//   Modports: master = lane-side producer / bench, slave = multiplexer.
// ---------------------------------------------------------------------------
interface mux_nto1_tdm_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int SELW   = 2
);
    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [NUM_CH*WIDTH-1:0]   in_data;
    logic [NUM_CH-1:0]         in_valid;
    logic [WIDTH-1:0]          data_out;
    logic                      valid_out;
    logic [SELW-1:0]           lane_out;
    logic                      frame_sof;

    modport master (
        output mode, sel, in_data, in_valid,
        input  data_out, valid_out, lane_out, frame_sof
    );

    modport slave (
        input  mode, sel, in_data, in_valid,
        output data_out, valid_out, lane_out, frame_sof
    );
endinterface

// File: rtl/mux_nto1_tdm.sv
// ---------------------------------------------------------------------------
// mux_nto1_tdm
//   Parametrised N-to-1 data/valid multiplexer. Serialises NUM_CH parallel
//   lanes onto one registered output stream running at the fast clock.
//   The lane is picked either by an internal round-robin counter (mode=1)
//   or by the external selector (mode=0). Latency is one clock.
//
//   Ports:
//     clk    fast-rate clock (NUM_CH x lane rate)
//     reset  synchronous, active-high; clears outputs and the counter
//     bus    mux_nto1_tdm_if.slave (mode, sel, in_data, in_valid in;
//            data_out, valid_out, lane_out, frame_sof out)
//
//   Build option:
//     MUX_NTO1_HOLD_LAST_EN  when defined, data_out holds its previous value
//                            while the selected lane is invalid or out of
//                            range; otherwise data_out is driven to 0.
//
//   SELW must equal $clog2(NUM_CH). For non-power-of-2 NUM_CH an external
//   sel >= NUM_CH matches no lane, which yields valid_out=0 and no data.
// ---------------------------------------------------------------------------

// Per-lane cell: passes its lane data/valid only when it is the selected lane
// and the lane is valid, so the top can OR-reduce all cells.
module mux_nto1_tdm_lane #(
    parameter int WIDTH = 8,
    parameter int SELW  = 2,
    parameter int LANE  = 0
) (
    input  logic [SELW-1:0]  lane,
    input  logic [WIDTH-1:0] d,
    input  logic             v,
    output logic [WIDTH-1:0] d_m,
    output logic             v_m
);
    logic hit;

    assign hit = (lane == SELW'(LANE));
    assign v_m = hit & v;
    assign d_m = v_m ? d : '0;
endmodule

module mux_nto1_tdm #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int SELW   = 2
) (
    input  logic           clk,
    input  logic           reset,
    mux_nto1_tdm_if.slave  bus
);
    logic [SELW-1:0]                 cnt;
    logic [SELW-1:0]                 lane;
    logic [NUM_CH-1:0][WIDTH-1:0]    lane_d;
    logic [NUM_CH-1:0][WIDTH-1:0]    d_m;
    logic [NUM_CH-1:0]               v_m;
    logic [WIDTH-1:0]                sel_data;
    logic                            sel_vld;

    assign lane_d = bus.in_data;
    assign lane   = bus.mode ? cnt : bus.sel;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        mux_nto1_tdm_lane #(
            .WIDTH (WIDTH),
            .SELW  (SELW),
            .LANE  (g)
        ) u_lane (
            .lane (lane),
            .d    (lane_d[g]),
            .v    (bus.in_valid[g]),
            .d_m  (d_m[g]),
            .v_m  (v_m[g])
        );
    end

    // At most one cell is active, so OR-reduction is a one-hot mux.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++)
            sel_data = sel_data | d_m[k];
    end

    assign sel_vld = |v_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.lane_out  <= '0;
            bus.frame_sof <= 1'b0;
        end else begin
            // Held at 0 in external mode so entering round-robin starts at lane 0.
            if (!bus.mode || cnt == SELW'(NUM_CH - 1))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            bus.lane_out  <= lane;
            bus.valid_out <= sel_vld;
            bus.frame_sof <= bus.mode && (cnt == '0);
`ifdef MUX_NTO1_HOLD_LAST_EN
            if (sel_vld)
                bus.data_out <= sel_data;
`else
            bus.data_out  <= sel_vld ? sel_data : '0;
`endif
        end
    end
endmodule

// File: tb/tb_mux_nto1_tdm.sv
// ---------------------------------------------------------------------------
// tb_mux_nto1_tdm
//   Two instances share clk/reset: A (NUM_CH=4, WIDTH=8) and B (NUM_CH=3,
//   WIDTH=16, exercising the out-of-range selector). A slot-position model
//   predicts every output of both instances each cycle.
// ---------------------------------------------------------------------------
module tb_mux_nto1_tdm;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mux_nto1_tdm_if #(.NUM_CH(4), .WIDTH(8),  .SELW(2)) ifa ();
    mux_nto1_tdm_if #(.NUM_CH(3), .WIDTH(16), .SELW(2)) ifb ();

    mux_nto1_tdm #(.NUM_CH(4), .WIDTH(8),  .SELW(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    mux_nto1_tdm #(.NUM_CH(3), .WIDTH(16), .SELW(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model state: slot position within the round-robin frame, last data out.
    int          pos_a = 0;
    int          pos_b = 0;
    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next outputs of one multiplexer given what is presented at the edge.
    function automatic void model(
        input  int          nch,
        input  int          w,
        input  bit          rst,
        input  bit          mode,
        input  int          sel,
        input  logic [63:0] din,
        input  logic [7:0]  vin,
        inout  int          pos,
        inout  logic [15:0] last,
        output logic [15:0] d,
        output bit          v,
        output int          lane,
        output bit          sof
    );
        d = '0; v = 1'b0; lane = 0; sof = 1'b0;
        if (rst) begin
            pos  = 0;
            last = '0;
            return;
        end
        lane = mode ? pos : sel;
        v    = (lane < nch) && vin[lane];
        sof  = mode && (pos == 0);
        if (v) begin
            for (int b = 0; b < w; b++) d[b] = din[lane*w + b];
        end else begin
`ifdef MUX_NTO1_HOLD_LAST_EN
            d = last;
`else
            d = '0;
`endif
        end
        pos  = mode ? (pos + 1) % nch : 0;
        last = d;
    endfunction

    task automatic step();
        logic [15:0] da, db;
        bit          va, vb, sa, sb;
        int          la, lb;
        model(4, 8, reset, ifa.mode, int'(ifa.sel), 64'(ifa.in_data), 8'(ifa.in_valid),
              pos_a, last_a, da, va, la, sa);
        model(3, 16, reset, ifb.mode, int'(ifb.sel), 64'(ifb.in_data), 8'(ifb.in_valid),
              pos_b, last_b, db, vb, lb, sb);
        @(posedge clk);
        #1;
        chk("a.data_out",  16'(ifa.data_out),  da);
        chk("a.valid_out", 16'(ifa.valid_out), 16'(va));
        chk("a.lane_out",  16'(ifa.lane_out),  16'(la));
        chk("a.frame_sof", 16'(ifa.frame_sof), 16'(sa));
        chk("b.data_out",  ifb.data_out,       db);
        chk("b.valid_out", 16'(ifb.valid_out), 16'(vb));
        chk("b.lane_out",  16'(ifb.lane_out),  16'(lb));
        chk("b.frame_sof", 16'(ifb.frame_sof), 16'(sb));
    endtask

    initial begin
        // Reset for two clocks with all lanes valid.
        reset        = 1'b1;
        ifa.mode     = 1'b1;
        ifa.sel      = 2'd0;
        ifa.in_data  = 32'h4433_2211;
        ifa.in_valid = 4'hF;
        ifb.mode     = 1'b1;
        ifb.sel      = 2'd0;
        ifb.in_data  = 48'h3333_2222_1111;
        ifb.in_valid = 3'b111;
        step();
        step();
        chk("a.reset_data", 16'(ifa.data_out), 16'h0000);

        // Round-robin, all lanes valid: 11,22,33,44,11.
        reset = 1'b0;
        step();
        chk("a.first_after_reset", 16'(ifa.data_out), 16'h0011);
        chk("a.first_sof",         16'(ifa.frame_sof), 16'h0001);
        repeat (4) step();

        // Lane 2 invalid in round-robin.
        ifa.in_valid = 4'b1011;
        repeat (5) step();

        // External select: lane 2 then lane 3.
        ifa.mode     = 1'b0;
        ifa.sel      = 2'd2;
        ifa.in_data  = 32'h44A5_2211;
        ifa.in_valid = 4'hF;
        step();
        chk("a.sel2_data", 16'(ifa.data_out), 16'h00A5);
        ifa.sel = 2'd3;
        step();
        chk("a.sel3_data", 16'(ifa.data_out), 16'h0044);

        // Reset mid-frame, then restart at lane 0.
        ifa.mode = 1'b1;
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();

        // Instance B: out-of-range select, then 3-lane round-robin.
        ifb.mode     = 1'b0;
        ifb.sel      = 2'd3;
        ifb.in_valid = 3'b111;
        step();
        chk("b.oor_lane",  16'(ifb.lane_out),  16'h0003);
        chk("b.oor_valid", 16'(ifb.valid_out), 16'h0000);
        ifb.mode = 1'b1;
        repeat (6) step();

        // Randomised traffic with occasional resets and mode changes.
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 39) == 0);
            ifa.mode     = ($urandom_range(0, 3) != 0);
            ifa.sel      = 2'($urandom_range(0, 3));
            ifa.in_data  = $urandom;
            ifa.in_valid = 4'($urandom);
            ifb.mode     = ($urandom_range(0, 3) != 0);
            ifb.sel      = 2'($urandom_range(0, 3));
            ifb.in_data  = {16'($urandom), 32'($urandom)};
            ifb.in_valid = 3'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
